// File: rtl/bs_ordered_decode.sv
// Stochastic-to-binary decoder for ordered (thermometer) or unordered bitstreams.
// It counts the ones in a window of 2^WIDTH accepted bits and reports the total.
// In ordered mode it can stop at the first 0, or consume the whole window and
// flag any 1 that arrives after a 0.
module bs_ordered_decode #(
  parameter int WIDTH      = 5,
  parameter int EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ordered,
  input  logic             bs_in,
  input  logic             bs_valid,
  output logic             bs_ready,
  output logic [WIDTH:0]   bin_out,
  output logic             bin_valid,
  output logic             busy,
  output logic             order_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index value of the final bit in a window (L-1), sized like the index counter.
  localparam logic [WIDTH:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};

  state_t         state_reg, state_next;
  logic [WIDTH:0] count_reg;
  logic [WIDTH:0] index_reg;
  logic           seen_zero_reg;
  logic           err_acc_reg;
  logic           mode_reg;
  logic [WIDTH:0] bin_out_reg;
  logic           order_err_reg;

  logic           beat;
  logic           last_beat;
  logic           early_hit;
  logic           term_beat;
  logic [WIDTH:0] count_post;
  logic           err_post;

  // Beat qualification and the post-beat values that get captured on termination.
  always_comb begin
    beat       = (state_reg == RUN) && bs_valid;
    last_beat  = (index_reg == LAST_IDX);
    early_hit  = (EARLY_TERM != 0) && mode_reg && !bs_in;
    term_beat  = beat && (last_beat || early_hit);
    count_post = count_reg + {{WIDTH{1'b0}}, bs_in};
    err_post   = err_acc_reg | (mode_reg & bs_in & seen_zero_reg);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (term_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic decoded from the state alone; bs_ready never looks at bs_valid.
  always_comb begin
    bs_ready  = (state_reg == RUN);
    busy      = (state_reg != IDLE);
    bin_valid = (state_reg == DONE);
  end

  // Window datapath: clear on accepted start, accumulate on every beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      index_reg     <= '0;
      seen_zero_reg <= 1'b0;
      err_acc_reg   <= 1'b0;
      mode_reg      <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      count_reg     <= '0;
      index_reg     <= '0;
      seen_zero_reg <= 1'b0;
      err_acc_reg   <= 1'b0;
      mode_reg      <= ordered;
    end else if (beat) begin
      count_reg   <= count_post;
      index_reg   <= index_reg + 1'b1;
      err_acc_reg <= err_post;
      if (mode_reg && !bs_in) begin
        seen_zero_reg <= 1'b1;
      end
    end
  end

  // Result registers hold until the next terminating beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out_reg   <= '0;
      order_err_reg <= 1'b0;
    end else if (term_beat) begin
      bin_out_reg   <= count_post;
      order_err_reg <= err_post;
    end
  end

  assign bin_out   = bin_out_reg;
  assign order_err = order_err_reg;

endmodule

// File: tb/tb_bs_ordered_decode.sv
// Testbench for bs_ordered_decode: two WIDTH=3 instances, one with early
// termination and one without, checked against a scoreboard of expected results.
module tb_bs_ordered_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       ordered = 1'b0;
  logic       bs_in = 1'b0;
  logic       bs_valid = 1'b0;

  logic       bs_ready_a, bin_valid_a, busy_a, order_err_a;
  logic [3:0] bin_out_a;
  logic       bs_ready_b, bin_valid_b, busy_b, order_err_b;
  logic [3:0] bin_out_b;

  int n_compared = 0;
  int n_mismatch = 0;
  int n_starts   = 0;
  int n_pulses   = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];

  always #5 clk = ~clk;

  bs_ordered_decode #(.WIDTH(3), .EARLY_TERM(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ordered(ordered),
    .bs_in(bs_in), .bs_valid(bs_valid), .bs_ready(bs_ready_a),
    .bin_out(bin_out_a), .bin_valid(bin_valid_a), .busy(busy_a),
    .order_err(order_err_a)
  );

  bs_ordered_decode #(.WIDTH(3), .EARLY_TERM(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ordered(ordered),
    .bs_in(bs_in), .bs_valid(bs_valid), .bs_ready(bs_ready_b),
    .bin_out(bin_out_b), .bin_valid(bin_valid_b), .busy(busy_b),
    .order_err(order_err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sel_ready(input bit which);
    return which ? bs_ready_b : bs_ready_a;
  endfunction

  function automatic logic sel_valid(input bit which);
    return which ? bin_valid_b : bin_valid_a;
  endfunction

  function automatic logic sel_busy(input bit which);
    return which ? busy_b : busy_a;
  endfunction

  // Reference model of one window over an 8-bit stream (bit i is beat i).
  task automatic model(input logic ord, input bit et, input logic [7:0] s,
                       output logic [3:0] cnt, output logic err, output int beats);
    logic seen;
    cnt = 0; err = 0; seen = 0; beats = 0;
    for (int i = 0; i < 8; i++) begin
      beats = i + 1;
      cnt = cnt + {3'b000, s[i]};
      if (ord) begin
        if (!s[i]) seen = 1'b1;
        else if (seen) err = 1'b1;
      end
      if (ord && et && !s[i]) break;
    end
  endtask

  // Drive one window. glitch >= 0 pulses start on beat 'glitch' and in DONE;
  // abort >= 0 asserts rst when that many beats have been taken.
  task automatic run_window(input bit which, input logic ord, input logic [7:0] s,
                            input bit toggle, input int glitch, input int abort);
    int idx = 0;
    int run_cyc = 0;
    int guard = 0;
    logic [3:0] ecnt;
    logic eerr;
    int ebeats;
    model(ord, !which, s, ecnt, eerr, ebeats);
    @(negedge clk);
    ordered = ord;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    n_starts++;
    if (abort < 0) begin
      if (which) q_b.push_back({eerr, ecnt}); else q_a.push_back({eerr, ecnt});
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    while (guard < 100) begin
      if (!sel_ready(which)) break;
      if (abort >= 0 && idx == abort) begin
        rst = 1'b1;
        bs_valid = 1'b0;
        #1;
        check_eq("rst_bin_out", which ? bin_out_b : bin_out_a, 0);
        check_eq("rst_order_err", which ? order_err_b : order_err_a, 0);
        check_eq("rst_busy", sel_busy(which), 0);
        check_eq("rst_bs_ready", sel_ready(which), 0);
        check_eq("rst_bin_valid", sel_valid(which), 0);
        @(negedge clk);
        rst = 1'b0;
        n_starts--;
        $display("window dut=%0d aborted by reset after %0d beats", which, idx);
        return;
      end
      run_cyc++;
      bs_valid = toggle ? ((run_cyc % 2) == 1) : 1'b1;
      bs_in = s[idx % 8];
      if (glitch == idx && bs_valid) begin
        if (which) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (bs_valid) idx++;
      @(negedge clk);
      guard++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    bs_valid = 1'b0;
    check_eq("timeout", guard >= 100, 0);
    check_eq("beats", idx, ebeats);
    check_eq("run_cycles", run_cyc, toggle ? 2 * ebeats - 1 : ebeats);
    check_eq("latency_bin_valid", sel_valid(which), 1);
    check_eq("done_bs_ready", sel_ready(which), 0);
    if (glitch >= 0) begin
      if (which) start_b = 1'b1; else start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check_eq("pulse_width", sel_valid(which), 0);
    check_eq("idle_busy", sel_busy(which), 0);
    $display("window dut=%0d ord=%0d stream=%02h beats=%0d exp_bin=%0d exp_err=%0d",
             which, ord, s, idx, ecnt, eerr);
  endtask

  // Scoreboard: pop and compare whenever either decoder presents a result.
  always @(negedge clk) begin
    logic [4:0] e;
    if (bin_valid_a) begin
      n_pulses++;
      if (q_a.size() == 0) check_eq("spurious_a", bin_valid_a, 0);
      else begin
        e = q_a.pop_front();
        check_eq("bin_out_a", bin_out_a, e[3:0]);
        check_eq("order_err_a", order_err_a, e[4]);
        $display("result dut=0 bin_out=%0d order_err=%0d", bin_out_a, order_err_a);
      end
    end
    if (bin_valid_b) begin
      n_pulses++;
      if (q_b.size() == 0) check_eq("spurious_b", bin_valid_b, 0);
      else begin
        e = q_b.pop_front();
        check_eq("bin_out_b", bin_out_b, e[3:0]);
        check_eq("order_err_b", order_err_b, e[4]);
        $display("result dut=1 bin_out=%0d order_err=%0d", bin_out_b, order_err_b);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_bin_out", bin_out_a, 0);
    check_eq("reset_bin_valid", bin_valid_a, 0);
    check_eq("reset_bs_ready", bs_ready_a, 0);
    check_eq("reset_busy", busy_a, 0);
    check_eq("reset_order_err", order_err_b, 0);
    rst = 1'b0;
    @(negedge clk);

    run_window(1'b0, 1'b0, 8'h4D, 1'b0, -1, -1); // 1,0,1,1,0,0,1,0 -> 4
    run_window(1'b0, 1'b1, 8'hF7, 1'b0,  3, -1); // 1,1,1,0 early stop, start on term beat
    run_window(1'b1, 1'b1, 8'h0B, 1'b0, -1, -1); // 1,1,0,1,0.. full window, err
    run_window(1'b0, 1'b1, 8'h0B, 1'b0, -1, -1); // early stop at beat 3 -> 2
    run_window(1'b0, 1'b0, 8'hFF, 1'b1, -1, -1); // all ones, toggling valid -> 8
    run_window(1'b1, 1'b1, 8'hFF, 1'b1, -1, -1); // ordered all ones, no err
    run_window(1'b0, 1'b1, 8'h00, 1'b0, -1, -1); // ordered zeros, 1 beat
    run_window(1'b0, 1'b0, 8'hFF, 1'b0, -1,  5); // reset after 5 beats
    run_window(1'b0, 1'b0, 8'h00, 1'b0, -1, -1); // all zeros after reset
    run_window(1'b1, 1'b0, 8'h4D, 1'b0,  2, -1); // start during RUN and DONE
    run_window(1'b1, 1'b1, 8'h55, 1'b0, -1, -1); // 1,0,1,0.. -> 4, err

    repeat (3) @(negedge clk);
    check_eq("pulse_count", n_pulses, n_starts);
    check_eq("queue_a_empty", q_a.size(), 0);
    check_eq("queue_b_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
